vga_overlay_mixer: RTL and testbench
====================================

# vga_overlay_mixer

Parametrised frame-buffer-to-VGA pixel path with multi-marker overlay. Sits between the VGA timing generator, the dual-port frame RAM and the VGA DAC pins. It turns raw VGA counters into frame-buffer read addresses and greyscale pixels into RGB. It draws up to N_MARK configurable markers whose positions arrive as linear pixel indices, converted to (x,y) by an internal shared sequential divider.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- H_OFFSET, 143, raw x counter value of first visible pixel
- V_OFFSET, 35, raw y counter value of first visible line
- ADDR_W, 20, frame-buffer address / marker position width
- PIX_W, 8, frame-buffer pixel width (greyscale, MSB-aligned onto 8-bit RGB)
- N_MARK, 2, number of markers
- ARM, 8, arm length / box half-size in pixels for modes 01 and 10
- CLOCK_50  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ativo  in  1  VGA active-video flag
- x, y  in  11 each  raw VGA counters
- rd_addr  out  ADDR_W  frame-buffer read address
- rd_data  in  PIX_W  frame-buffer data, valid 1 cycle after rd_addr
- mark_pos  in  N_MARK*ADDR_W  linear pixel index per marker (marker i at bits [i*ADDR_W +: ADDR_W])
- mark_load  in  N_MARK  1-cycle strobe: capture mark_pos slice i
- mark_en  in  N_MARK  draw enable per marker
- mark_mode  in  N_MARK*2  00 full crosshair, 01 short cross, 10 box outline, 11 off
- mark_color  in  N_MARK*24  {R,G,B} per marker
- mark_busy  out  1  divider running or any load pending
- mark_reject  out  1  1-cycle pulse: conversion discarded (out of range)
- vga_r, vga_g, vga_b  out  8 each  pixel colour

## Operation
- Coordinates: px = x − H_OFFSET, py = y − V_OFFSET, computed 12-bit signed. in_frame = ativo && 0 ≤ px < H_ACTIVE && 0 ≤ py < V_ACTIVE.
- Address: rd_addr = py*H_ACTIVE + px when in_frame; otherwise rd_addr holds its last value.
- Base colour: rd_data left-justified to 8 bits, copied to R, G, B. Outside in_frame output is 0,0,0.
- Marker hit (dx = px − mx, dy = py − my, signed):
  - 00: dx==0 || dy==0
  - 01: (dx==0 && |dy|≤ARM) || (dy==0 && |dx|≤ARM)
  - 10: |dx|≤ARM && |dy|≤ARM && (|dx|==ARM || |dy|==ARM)
  - 11: never
- A marker draws only if mark_en[i] && coord_valid[i]. The lowest index hit wins and replaces the base colour with mark_color[i].
- Loader: mark_load[i] latches the slice into pend_pos[i] and sets pend[i]. A reload while pend[i] is set overwrites pend_pos[i], newest value wins.
- Divider FSM: IDLE → LOAD → DIV → STORE → IDLE.
  - IDLE selects the lowest-index pending marker and clears its pend bit in LOAD.
  - DIV runs a restoring division by H_ACTIVE, ADDR_W iterations, one per cycle.
  - STORE: if quotient < V_ACTIVE, writes mx = remainder, my = quotient and sets coord_valid[i]. Otherwise it pulses mark_reject and leaves the coordinates unchanged.
  - A load for the marker being converted during LOAD..STORE re-pends it. It is converted again afterwards; the in-flight result is still stored.
- Drawing always uses the committed mx/my. The committed values change only in STORE, so there is never a half-updated pair.
- Reset values:
  - pipeline flags, pend, coord_valid = 0; mx = my = 0
  - FSM in IDLE
  - rd_addr = 0, mark_busy = 0, mark_reject = 0
  - RGB = 0
  - A reset mid-conversion abandons that conversion and any pending loads.

## Timing
- Pixel pipeline is fixed and does not depend on marker activity.
  - cycle 0: x,y,ativo sampled
  - cycle 1: rd_addr and in_frame registered
  - cycle 2: rd_data valid, hit flags registered, delayed to align with rd_data
  - cycle 3: vga_r/g/b registered
- x,y to RGB latency = 3 cycles. The timing generator delays sync by 3 to compensate.
- Marker update latency: mark_load at cycle t, with the FSM idle, gives new coordinates visible at cycle t+ADDR_W+3. The first drawn pixel using them is 3 cycles after the x,y sample that follows.
- mark_busy rises the cycle after mark_load and falls the cycle after the last STORE.
- Simultaneous loads on several markers are all captured and serviced in ascending index order.

## Test plan
- Reset asserted for 2 cycles with arbitrary inputs → RGB = 0, rd_addr = 0, mark_busy = 0 from the next cycle.
- x=143, y=35, ativo=1, rd_data=8'h5A, no markers → rd_addr = 0 one cycle later; RGB = 5A,5A,5A three cycles after the x,y sample. x=782, y=514 → rd_addr = 307199.
- mark_pos[0]=12345, mark_load[0] pulse, mode 00, colour 0000FF, enabled → after 23 cycles mx=185, my=19. Every pixel with px=185 or py=19 is blue; all others show the frame buffer.
- Markers 0 and 1 at the same position with different colours, both mode 01 → overlap shows marker 0 colour. An arm pixel at dx=8 is drawn; dx=9 is not.
- mark_pos[1]=307200 loaded → mark_reject pulses once and marker 1 is never drawn. Both markers loaded in the same cycle → marker 0 converts first, marker 1 second, mark_busy high for 2×(ADDR_W+3) cycles.
- Reload of marker 0 during DIV → its first result is stored, then the second result. Reset asserted mid-DIV → coord_valid = 0 and FSM in IDLE on the next cycle.

Source files
------------

// File: rtl/vga_overlay_mixer.sv
// Frame-buffer to VGA pixel path with a multi-marker overlay.
// Pixel path is a fixed 3-stage pipeline; marker positions arrive as linear
// pixel indices and are turned into (x,y) by one shared restoring divider.

// Per-marker hit test against the current pixel coordinate.
module vga_overlay_marker_hit #(
    parameter int ARM = 8
) (
    input  logic signed [11:0] px,
    input  logic signed [11:0] py,
    input  logic [10:0]        mx,
    input  logic [10:0]        my,
    input  logic [1:0]         mode,
    input  logic               active,
    output logic               hit
);
    logic signed [12:0] dx, dy;
    logic [12:0]        adx, ady;

    // Signed offsets, magnitudes and the mode-dependent shape test
    always_comb begin
        dx  = {px[11], px} - $signed({2'b00, mx});
        dy  = {py[11], py} - $signed({2'b00, my});
        adx = dx[12] ? 13'(-dx) : 13'(dx);
        ady = dy[12] ? 13'(-dy) : 13'(dy);
        hit = 1'b0;
        case (mode)
            2'b00: hit = (dx == 0) || (dy == 0);
            2'b01: hit = ((dx == 0) && (ady <= 13'(ARM))) || ((dy == 0) && (adx <= 13'(ARM)));
            2'b10: hit = (adx <= 13'(ARM)) && (ady <= 13'(ARM)) &&
                         ((adx == 13'(ARM)) || (ady == 13'(ARM)));
            default: hit = 1'b0;
        endcase
        hit = hit && active;
    end
endmodule

module vga_overlay_mixer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_OFFSET = 143,
    parameter int V_OFFSET = 35,
    parameter int ADDR_W   = 20,
    parameter int PIX_W    = 8,
    parameter int N_MARK   = 2,
    parameter int ARM      = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     ativo,
    input  logic [10:0]              x,
    input  logic [10:0]              y,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [PIX_W-1:0]         rd_data,
    input  logic [N_MARK*ADDR_W-1:0] mark_pos,
    input  logic [N_MARK-1:0]        mark_load,
    input  logic [N_MARK-1:0]        mark_en,
    input  logic [N_MARK*2-1:0]      mark_mode,
    input  logic [N_MARK*24-1:0]     mark_color,
    output logic                     mark_busy,
    output logic                     mark_reject,
    output logic [7:0]               vga_r,
    output logic [7:0]               vga_g,
    output logic [7:0]               vga_b
);
    localparam int SEL_W = (N_MARK > 1) ? $clog2(N_MARK) : 1;
    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam logic [ADDR_W:0] DIVISOR = (ADDR_W + 1)'(H_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_STORE} state_t;

    // Pixel pipeline state
    logic signed [11:0]  px0, py0, px_q, py_q;
    logic                in_frame0;
    logic [ADDR_W-1:0]   rd_addr_d, rd_addr_q;
    logic [1:0]          vld_pipe_q;          // [0]: stage 1, [1]: stage 2
    logic [N_MARK-1:0]   hit_c, hit_q;
    logic [23:0]         rgb_d, rgb_q;
    logic [7:0]          base;

    // Marker loader / divider state
    state_t                           state_d, state_q;
    logic [SEL_W-1:0]                 sel_d, sel_q;
    logic [N_MARK-1:0]                pend_d, pend_q;
    logic [N_MARK-1:0][ADDR_W-1:0]    pend_pos_d, pend_pos_q;
    logic [ADDR_W-1:0]                rem_d, rem_q, quo_d, quo_q;
    logic [ADDR_W:0]                  rem_sh;
    logic [CNT_W-1:0]                 cnt_d, cnt_q;
    logic [N_MARK-1:0][10:0]          mx_d, mx_q, my_d, my_q;
    logic [N_MARK-1:0]                coord_valid_d, coord_valid_q;
    logic                             reject_d, reject_q;

    // Stage 0: raw counters to frame coordinates and read address
    always_comb begin
        px0       = $signed({1'b0, x}) - $signed(12'(H_OFFSET));
        py0       = $signed({1'b0, y}) - $signed(12'(V_OFFSET));
        in_frame0 = ativo && (px0 >= 0) && (px0 < $signed(12'(H_ACTIVE))) &&
                    (py0 >= 0) && (py0 < $signed(12'(V_ACTIVE)));
        rd_addr_d = in_frame0 ? ADDR_W'($unsigned(py0)) * ADDR_W'(H_ACTIVE) + ADDR_W'($unsigned(px0))
                              : rd_addr_q;
    end

    // Stage 1: one hit tester per marker, always on committed coordinates
    for (genvar g = 0; g < N_MARK; g++) begin : g_hit
        vga_overlay_marker_hit #(.ARM(ARM)) u_hit (
            .px     (px_q),
            .py     (py_q),
            .mx     (mx_q[g]),
            .my     (my_q[g]),
            .mode   (mark_mode[g*2 +: 2]),
            .active (mark_en[g] && coord_valid_q[g]),
            .hit    (hit_c[g])
        );
    end

    // Stage 2: greyscale to RGB, lowest-index hit overrides the base colour
    always_comb begin
        base  = 8'(rd_data) << (8 - PIX_W);
        rgb_d = {base, base, base};
        for (int i = N_MARK - 1; i >= 0; i--)
            if (hit_q[i]) rgb_d = mark_color[i*24 +: 24];
        if (!vld_pipe_q[1]) rgb_d = 24'h0;
    end

    // Divider FSM and marker loader next-state
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pend_d        = pend_q;
        pend_pos_d    = pend_pos_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        cnt_d         = cnt_q;
        mx_d          = mx_q;
        my_d          = my_q;
        coord_valid_d = coord_valid_q;
        reject_d      = 1'b0;
        rem_sh        = {rem_q, quo_q[ADDR_W-1]};
        case (state_q)
            S_IDLE: if (|pend_q) begin
                for (int i = N_MARK - 1; i >= 0; i--)
                    if (pend_q[i]) sel_d = SEL_W'(i);
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pend_d[sel_q] = 1'b0;
                quo_d         = pend_pos_q[sel_q];
                rem_d         = '0;
                cnt_d         = '0;
                state_d       = S_DIV;
            end
            S_DIV: begin
                if (rem_sh >= DIVISOR) begin
                    rem_d = ADDR_W'(rem_sh - DIVISOR);
                    quo_d = {quo_q[ADDR_W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[ADDR_W-1:0];
                    quo_d = {quo_q[ADDR_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ADDR_W - 1)) state_d = S_STORE;
            end
            default: begin  // S_STORE: commit x/y as a pair, or discard
                if (quo_q < ADDR_W'(V_ACTIVE)) begin
                    mx_d[sel_q]          = rem_q[10:0];
                    my_d[sel_q]          = quo_q[10:0];
                    coord_valid_d[sel_q] = 1'b1;
                end else begin
                    reject_d = 1'b1;
                end
                state_d = S_IDLE;
            end
        endcase
        // New loads come last so a reload during LOAD re-pends the marker
        for (int i = 0; i < N_MARK; i++)
            if (mark_load[i]) begin
                pend_d[i]     = 1'b1;
                pend_pos_d[i] = mark_pos[i*ADDR_W +: ADDR_W];
            end
    end

    // All state registers, synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            px_q <= '0; py_q <= '0; rd_addr_q <= '0; vld_pipe_q <= '0;
            hit_q <= '0; rgb_q <= '0;
            state_q <= S_IDLE; sel_q <= '0; pend_q <= '0; pend_pos_q <= '0;
            rem_q <= '0; quo_q <= '0; cnt_q <= '0;
            mx_q <= '0; my_q <= '0; coord_valid_q <= '0; reject_q <= 1'b0;
        end else begin
            px_q <= px0; py_q <= py0; rd_addr_q <= rd_addr_d;
            vld_pipe_q <= {vld_pipe_q[0], in_frame0};
            hit_q <= hit_c; rgb_q <= rgb_d;
            state_q <= state_d; sel_q <= sel_d; pend_q <= pend_d; pend_pos_q <= pend_pos_d;
            rem_q <= rem_d; quo_q <= quo_d; cnt_q <= cnt_d;
            mx_q <= mx_d; my_q <= my_d; coord_valid_q <= coord_valid_d; reject_q <= reject_d;
        end
    end

    assign rd_addr     = rd_addr_q;
    assign mark_busy   = (|pend_q) || (state_q != S_IDLE);
    assign mark_reject = reject_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_overlay_mixer.sv
// Directed bench for vga_overlay_mixer: a vector table for the pixel path
// plus hand sequences for marker conversion, reject, reload and reset.
module tb_vga_overlay_mixer;
    logic        clk = 1'b0;
    logic        reset, ativo;
    logic [10:0] x, y;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data = 8'h0;
    logic [39:0] mark_pos;
    logic [1:0]  mark_load, mark_en;
    logic [3:0]  mark_mode;
    logic [47:0] mark_color;
    logic        mark_busy, mark_reject;
    logic [7:0]  vga_r, vga_g, vga_b;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [10:0] x, y;
        logic        ativo;
        logic [1:0]  en;
        logic [3:0]  mode;
        logic [19:0] addr;
        logic [23:0] rgb;
    } vec_t;
    vec_t tab[21];

    vga_overlay_mixer dut (
        .CLOCK_50(clk), .reset(reset), .ativo(ativo), .x(x), .y(y),
        .rd_addr(rd_addr), .rd_data(rd_data), .mark_pos(mark_pos),
        .mark_load(mark_load), .mark_en(mark_en), .mark_mode(mark_mode),
        .mark_color(mark_color), .mark_busy(mark_busy), .mark_reject(mark_reject),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    // Frame RAM: synchronous read, pixel = low address byte ^ 5A
    always @(posedge clk) rd_data <= rd_addr[7:0] ^ 8'h5A;

    function automatic vec_t mk(input int vx, input int vy, input logic a, input logic [1:0] en,
                                input logic [3:0] mode, input int addr, input logic [23:0] rgb);
        vec_t v;
        v.x = 11'(vx); v.y = 11'(vy); v.ativo = a; v.en = en; v.mode = mode;
        v.addr = 20'(addr); v.rgb = rgb;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hold one pixel for the full pipeline depth; address after 1, RGB after 3
    task automatic pix(input vec_t v, input string nm);
        x = v.x; y = v.y; ativo = v.ativo; mark_en = v.en; mark_mode = v.mode;
        tick;
        chk({nm, " addr"}, 32'(rd_addr), 32'(v.addr));
        tick;
        tick;
        chk({nm, " rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(v.rgb));
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pix(tab[i], $sformatf("vec%0d", i));
    endtask

    task automatic load(input logic [1:0] which, input int p0, input int p1);
        mark_pos = {20'(p1), 20'(p0)};
        mark_load = which;
        tick;
        mark_load = 2'b00;
    endtask

    // Count cycles until busy drops (bounded) and reject pulses seen meanwhile
    task automatic wait_idle(input int exp_n, input int exp_rej, input string nm);
        int n = 0;
        int rej = 0;
        while (mark_busy && n < 300) begin
            tick;
            n++;
            if (mark_reject) rej++;
        end
        chk({nm, " busy cycles"}, 32'(n), 32'(exp_n));
        chk({nm, " reject pulses"}, 32'(rej), 32'(exp_rej));
    endtask

    initial begin
        // Phase A: no markers
        tab[0]  = mk(143, 35, 1, 2'b00, 4'h0, 0, 24'h5A5A5A);
        tab[1]  = mk(782, 514, 1, 2'b00, 4'h0, 307199, 24'hA5A5A5);
        tab[2]  = mk(783, 35, 1, 2'b00, 4'h0, 307199, 24'h000000);
        tab[3]  = mk(142, 36, 1, 2'b00, 4'h0, 307199, 24'h000000);
        tab[4]  = mk(300, 100, 0, 2'b00, 4'h0, 307199, 24'h000000);
        tab[5]  = mk(153, 36, 1, 2'b00, 4'h0, 650, 24'hD0D0D0);
        tab[6]  = mk(143, 515, 1, 2'b00, 4'h0, 650, 24'h000000);
        // Phase B: marker 0 at (185,19) crosshair, marker 1 not yet valid
        tab[7]  = mk(328, 35, 1, 2'b11, 4'h0, 185, 24'h0000FF);
        tab[8]  = mk(143, 54, 1, 2'b11, 4'h0, 12160, 24'h0000FF);
        tab[9]  = mk(329, 55, 1, 2'b11, 4'h0, 12986, 24'hE0E0E0);
        tab[10] = mk(328, 54, 1, 2'b11, 4'h0, 12345, 24'h0000FF);
        tab[11] = mk(328, 54, 1, 2'b10, 4'h0, 12345, 24'h636363);
        // Phase C: both markers at (185,19)
        tab[12] = mk(328, 54, 1, 2'b11, 4'b0101, 12345, 24'h0000FF);
        tab[13] = mk(336, 54, 1, 2'b11, 4'b0101, 12353, 24'h0000FF);
        tab[14] = mk(337, 54, 1, 2'b11, 4'b0101, 12354, 24'h181818);
        tab[15] = mk(328, 46, 1, 2'b11, 4'b0101, 7225, 24'h0000FF);
        tab[16] = mk(328, 63, 1, 2'b11, 4'b0101, 18105, 24'hE3E3E3);
        tab[17] = mk(328, 54, 1, 2'b10, 4'b0101, 12345, 24'hFF0000);
        tab[18] = mk(336, 57, 1, 2'b11, 4'b1110, 14273, 24'h0000FF);
        tab[19] = mk(331, 57, 1, 2'b11, 4'b1110, 14268, 24'hE6E6E6);
        tab[20] = mk(328, 35, 1, 2'b11, 4'b0011, 185, 24'hFF0000);

        mark_color = {24'hFF0000, 24'h0000FF};
        // Reset with arbitrary inputs, including load strobes
        reset = 1'b1; ativo = 1'b1; x = 11'd200; y = 11'd50;
        mark_pos = {20'd777, 20'd999}; mark_load = 2'b11; mark_en = 2'b11; mark_mode = 4'h0;
        tick;
        tick;
        chk("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        chk("reset rd_addr", 32'(rd_addr), 32'h0);
        chk("reset busy", 32'(mark_busy), 32'h0);
        chk("reset reject", 32'(mark_reject), 32'h0);
        mark_load = 2'b00;
        reset = 1'b0;
        tick;
        chk("post-reset busy", 32'(mark_busy), 32'h0);

        run_range(0, 6);

        // Marker 0 conversion: 12345 -> (185,19)
        load(2'b01, 12345, 0);
        chk("busy after load", 32'(mark_busy), 32'h1);
        wait_idle(23, 0, "m0 load");
        run_range(7, 11);

        // Out-of-range position on marker 1
        load(2'b10, 0, 307200);
        wait_idle(23, 1, "m1 reject");
        pix(mk(328, 54, 1, 2'b10, 4'h0, 12345, 24'h636363), "m1 rejected not drawn");

        // Simultaneous loads serviced back to back
        load(2'b11, 12345, 12345);
        chk("busy after dual load", 32'(mark_busy), 32'h1);
        wait_idle(46, 0, "dual load");
        run_range(12, 20);

        // Reload of marker 0 during DIV: first result, then second
        load(2'b01, 64050, 0);              // (50,100)
        tick; tick; tick;
        load(2'b01, 128300, 0);             // (300,200)
        for (int i = 0; i < 19; i++) tick;
        pix(mk(193, 35, 1, 2'b01, 4'h0, 50, 24'h0000FF), "reload first result");
        wait_idle(20, 0, "reload");
        pix(mk(443, 35, 1, 2'b01, 4'h0, 300, 24'h0000FF), "reload second result");
        pix(mk(193, 35, 1, 2'b01, 4'h0, 50, 24'h686868), "reload old gone");

        // Reset in the middle of DIV abandons everything
        load(2'b11, 640, 1280);
        for (int i = 0; i < 8; i++) tick;
        chk("busy mid-div", 32'(mark_busy), 32'h1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("busy after mid reset", 32'(mark_busy), 32'h0);
        tick; tick; tick;
        chk("busy stays idle", 32'(mark_busy), 32'h0);
        pix(mk(443, 35, 1, 2'b01, 4'h0, 300, 24'h767676), "coord_valid cleared");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
